avalon_read_arbiter: RTL

AVALON_READ_ARBITER -- requirements
Module: avalon_read_arbiter

---
 rtl/avalon_read_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/avalon_read_arbiter.sv
// Two-port Avalon-MM read arbiter with in-order return routing.
// Port 0 (VGA) may jump ahead when urgent, bounded by a starvation limit.
module avalon_read_arbiter #(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 32,
   parameter int MAX_OUT    = 16,
   parameter int STARVE_LIM = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        r0_address,
   input  logic                     r0_read,
   input  logic                     r0_urgent,
   output logic                     r0_waitrequest,
   output logic                     r0_readdatavalid,
   input  logic [ADDR_W-1:0]        r1_address,
   input  logic                     r1_read,
   output logic                     r1_waitrequest,
   output logic                     r1_readdatavalid,
   output logic [DATA_W-1:0]        rd_readdata,
   output logic [ADDR_W-1:0]        m_address,
   output logic                     m_read,
   input  logic                     m_waitrequest,
   input  logic [DATA_W-1:0]        m_readdata,
   input  logic                     m_readdatavalid,
   output logic [$clog2(MAX_OUT):0] outstanding,
   output logic                     err_underflow
);

   localparam int PW = $clog2(MAX_OUT);
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [PW:0]   OUT_MAX = (PW+1)'(MAX_OUT);
   localparam logic [SW-1:0] S_LIM   = SW'(STARVE_LIM);

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G0     = 2'd1;
   localparam logic [1:0] G1     = 2'd2;

   logic [1:0]         grant, grant_nx;
   logic               last, last_nx;
   logic               by_urg, by_urg_nx;
   logic [SW-1:0]      starve, starve_nx;
   logic [MAX_OUT-1:0] owner;
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic               sel0, sel1, full, empty;
   logic               req, accept, stall, pop;

   assign sel0  = (grant == G0);
   assign sel1  = (grant == G1);
   assign full  = (outstanding == OUT_MAX);
   assign empty = (outstanding == '0);

   assign req    = (sel0 & r0_read) | (sel1 & r1_read);
   assign m_read = req & ~full;
   assign m_address = sel1 ? r1_address : r0_address;
   assign accept = m_read & ~m_waitrequest;
   assign stall  = m_read & m_waitrequest;

   assign r0_waitrequest = ~(accept & sel0);
   assign r1_waitrequest = ~(accept & sel1);

   assign pop = m_readdatavalid & ~empty;
   assign r0_readdatavalid = pop & ~owner[rd_ptr];
   assign r1_readdatavalid = pop & owner[rd_ptr];
   assign rd_readdata = m_readdata;

   // Next grant: hold during a stall, else re-arbitrate on this cycle's outcome
   always_comb begin
      starve_nx = starve;
      if (!r1_read)
         starve_nx = '0;
      else if (accept && sel1)
         starve_nx = '0;
      else if (accept && by_urg && starve != S_LIM)
         starve_nx = starve + 1'b1;

      last_nx = accept ? sel1 : last;

      grant_nx  = G_NONE;
      by_urg_nx = 1'b0;
      if (stall) begin
         grant_nx  = grant;
         by_urg_nx = by_urg;
      end else if (r0_read && r0_urgent && starve_nx < S_LIM) begin
         grant_nx  = G0;
         by_urg_nx = 1'b1;
      end else if (r0_read && r1_read) begin
         grant_nx = last_nx ? G0 : G1;
      end else if (r0_read) begin
         grant_nx = G0;
      end else if (r1_read) begin
         grant_nx = G1;
      end
   end

   // Arbiter state, owner FIFO pointers, outstanding count, sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant         <= G_NONE;
         last          <= 1'b1;
         by_urg        <= 1'b0;
         starve        <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         outstanding   <= '0;
         err_underflow <= 1'b0;
      end else begin
         grant  <= grant_nx;
         last   <= last_nx;
         by_urg <= by_urg_nx;
         starve <= starve_nx;
         if (accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (m_readdatavalid && empty)
            err_underflow <= 1'b1;
      end
   end

   // Owner FIFO storage: records which port each accepted read belongs to
   always_ff @(posedge clk) begin
      if (accept)
         owner[wr_ptr] <= sel1;
   end

endmodule
